// File: rtl/pc_redirect_sequencer.sv
// Fetch PC owner: picks PC+4 / jump / branch target each cycle, parks redirects
// that arrive under stall, and emits redirect and IF/ID flush pulses.
module pc_redirect_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = {WIDTH{1'b0}},
  parameter int unsigned      FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_stall,
  input  logic             in_branch_taken,
  input  logic [WIDTH-1:0] in_branch_target,
  input  logic             in_jump,
  input  logic [WIDTH-1:0] in_jump_target,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc_plus4,
  output logic             out_sel_branch,
  output logic             out_sel_jump,
  output logic             out_flush,
  output logic             out_redirect
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t           state_r;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pend_r;
  logic [WIDTH-1:0] pend_nxt;
  logic [2:0]       cnt_r;
  logic [2:0]       cnt_nxt;
  logic             flush_r;
  logic             redir_r;
  logic             redir_nxt;
  logic [WIDTH-1:0] branch_al;
  logic [WIDTH-1:0] jump_al;
  logic [WIDTH-1:0] redir_tgt;
  logic             redir_req;

  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
    return {addr[WIDTH-1:2], 2'b00};
  endfunction

  assign branch_al      = word_align(in_branch_target);
  assign jump_al        = word_align(in_jump_target);
  assign redir_req      = in_branch_taken | in_jump;
  // Older EX branch beats the younger ID jump.
  assign redir_tgt      = in_branch_taken ? branch_al : jump_al;

  assign out_sel_branch = in_branch_taken;
  assign out_sel_jump   = in_jump & ~in_branch_taken;
  assign out_pc         = pc_r;
  assign out_pc_plus4   = pc_r + WIDTH'(32'd4);
  assign out_flush      = flush_r;
  assign out_redirect   = redir_r;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
      pend_r  <= {WIDTH{1'b0}};
      cnt_r   <= 3'd0;
      flush_r <= 1'b0;
      redir_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      pc_r    <= pc_nxt;
      pend_r  <= pend_nxt;
      cnt_r   <= cnt_nxt;
      flush_r <= (cnt_nxt != 3'd0);
      redir_r <= redir_nxt;
    end
  end

  // Next state and pending-target capture.
  always_comb begin
    state_nxt = state_r;
    pend_nxt  = pend_r;
    case (state_r)
      RUN: begin
        if (in_stall && redir_req) begin
          state_nxt = PEND;
          pend_nxt  = redir_tgt;
        end else begin
          state_nxt = RUN;
        end
      end
      PEND: begin
        // A jump seen while parked is younger than the parked redirect.
        if (in_branch_taken) begin
          pend_nxt = branch_al;
        end else begin
          pend_nxt = pend_r;
        end
        if (in_stall) begin
          state_nxt = PEND;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        pend_nxt  = {WIDTH{1'b0}};
      end
    endcase
  end

  // Next PC, redirect pulse and flush counter.
  always_comb begin
    pc_nxt    = pc_r;
    redir_nxt = 1'b0;
    case (state_r)
      RUN: begin
        if (in_stall) begin
          pc_nxt    = pc_r;
          redir_nxt = 1'b0;
        end else if (redir_req) begin
          pc_nxt    = redir_tgt;
          redir_nxt = 1'b1;
        end else begin
          pc_nxt    = out_pc_plus4;
          redir_nxt = 1'b0;
        end
      end
      PEND: begin
        if (in_stall) begin
          pc_nxt    = pc_r;
          redir_nxt = 1'b0;
        end else if (in_branch_taken) begin
          pc_nxt    = branch_al;
          redir_nxt = 1'b1;
        end else begin
          pc_nxt    = pend_r;
          redir_nxt = 1'b1;
        end
      end
      default: begin
        pc_nxt    = RESET_PC;
        redir_nxt = 1'b0;
      end
    endcase
    // A fresh redirect restarts the flush window rather than extending it.
    if (redir_nxt) begin
      cnt_nxt = FLUSH_LOAD;
    end else if (cnt_r != 3'd0) begin
      cnt_nxt = cnt_r - 3'd1;
    end else begin
      cnt_nxt = 3'd0;
    end
  end

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Bench for pc_redirect_sequencer: directed vector table, hand sequences for
// reset/wrap/flush restart, and random traffic against a behavioural model.
module tb_pc_redirect_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] bt;
  logic        jmp;
  logic [31:0] jt;

  logic [31:0] pc1, pc1_p4, pc3, pc3_p4;
  logic        sb1, sj1, fl1, rd1, sb3, sj3, fl3, rd3;

  int n_chk  = 0;
  int n_fail = 0;

  pc_redirect_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_stall(stall), .in_branch_taken(br),
    .in_branch_target(bt), .in_jump(jmp), .in_jump_target(jt),
    .out_pc(pc1), .out_pc_plus4(pc1_p4), .out_sel_branch(sb1), .out_sel_jump(sj1),
    .out_flush(fl1), .out_redirect(rd1));

  pc_redirect_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_stall(stall), .in_branch_taken(br),
    .in_branch_target(bt), .in_jump(jmp), .in_jump_target(jt),
    .out_pc(pc3), .out_pc_plus4(pc3_p4), .out_sel_branch(sb3), .out_sel_jump(sj3),
    .out_flush(fl3), .out_redirect(rd3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural PC, an optional parked target, and
  // remaining flush cycles for each instance.
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ppc;
  int          m_fl1, m_fl3;
  bit          m_rd;

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 1'b0; m_ppc = 32'h0; m_fl1 = 0; m_fl3 = 0; m_rd = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit b, input logic [31:0] btgt,
                            input bit j, input logic [31:0] jtgt);
    logic [31:0] ba = btgt & 32'hFFFF_FFFC;
    logic [31:0] ja = jtgt & 32'hFFFF_FFFC;
    bit redir = 1'b0;
    if (m_pend) begin
      if (b) m_ppc = ba;
      if (!s) begin
        m_pc = m_ppc; redir = 1'b1; m_pend = 1'b0;
      end
    end else if (!s) begin
      if (b)      begin m_pc = ba; redir = 1'b1; end
      else if (j) begin m_pc = ja; redir = 1'b1; end
      else        m_pc = m_pc + 32'd4;
    end else if (b || j) begin
      m_pend = 1'b1; m_ppc = b ? ba : ja;
    end
    m_rd  = redir;
    m_fl1 = redir ? 1 : (m_fl1 > 0 ? m_fl1 - 1 : 0);
    m_fl3 = redir ? 3 : (m_fl3 > 0 ? m_fl3 - 1 : 0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive at the negedge, check selects mid-low-phase, check
  // registered outputs at the following negedge.
  task automatic cycle(input bit s, input bit b, input logic [31:0] btgt,
                       input bit j, input logic [31:0] jtgt);
    stall = s; br = b; bt = btgt; jmp = j; jt = jtgt;
    #1;
    chk("sel_branch", {63'd0, sb1}, {63'd0, b});
    chk("sel_jump",   {63'd0, sj1}, {63'd0, j & ~b});
    chk("pc_plus4",   {32'd0, pc1_p4}, {32'd0, m_pc + 32'd4});
    chk("sel_jump3",  {63'd0, sj3}, {63'd0, j & ~b});
    @(posedge clk);
    model_step(s, b, btgt, j, jtgt);
    @(negedge clk);
    chk("pc",        {32'd0, pc1}, {32'd0, m_pc});
    chk("pc3",       {32'd0, pc3}, {32'd0, m_pc});
    chk("redirect",  {63'd0, rd1}, {63'd0, m_rd});
    chk("redirect3", {63'd0, rd3}, {63'd0, m_rd});
    chk("flush",     {63'd0, fl1}, {63'd0, m_fl1 != 0});
    chk("flush3",    {63'd0, fl3}, {63'd0, m_fl3 != 0});
  endtask

  typedef struct {
    bit          s;
    bit          b;
    logic [31:0] btgt;
    bit          j;
    logic [31:0] jtgt;
    logic [31:0] exp_pc;
    bit          exp_flush;
    bit          exp_redir;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int flush_cnt;
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h4,   1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h8,   1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'hC,   1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h10,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'hF,  1'b1, 32'hA,   32'hC,   1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h10,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40,  32'h10,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   32'h10,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   32'h10,  1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40,  32'h40,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h80, 1'b0, 32'h0,   32'h40,  1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h80,  1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h84,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h100, 32'h84,  1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h200, 32'h84,  1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h100, 1'b1, 1'b1};

    rst_n = 1'b0; stall = 1'b0; br = 1'b0; bt = 32'h0; jmp = 1'b0; jt = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_pc",    {32'd0, pc1}, 64'd0);
    chk("reset_flush", {63'd0, fl1}, 64'd0);
    chk("reset_redir", {63'd0, rd1}, 64'd0);
    rst_n = 1'b1;

    // Directed table: sequential, branch-vs-jump, stalled jump, PEND override.
    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].s, vecs[i].b, vecs[i].btgt, vecs[i].j, vecs[i].jtgt);
      chk($sformatf("vec%0d_pc", i),    {32'd0, pc1}, {32'd0, vecs[i].exp_pc});
      chk($sformatf("vec%0d_flush", i), {63'd0, fl1}, {63'd0, vecs[i].exp_flush});
      chk($sformatf("vec%0d_redir", i), {63'd0, rd1}, {63'd0, vecs[i].exp_redir});
    end

    // Wrap plus back-to-back redirects: 3-cycle flush restarts, 4 cycles high.
    flush_cnt = 0;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
    flush_cnt += int'(fl3);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    flush_cnt += int'(fl3);
    chk("pre_wrap_pc", {32'd0, pc1}, {32'd0, 32'hFFFF_FFFC});
    chk("wrap_plus4",  {32'd0, pc1_p4}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      flush_cnt += int'(fl3);
      if (i == 0) chk("wrap_pc", {32'd0, pc1}, 64'd0);
    end
    chk("flush3_restart_len", 64'(flush_cnt), 64'd4);

    // Async reset mid-cycle discards a parked redirect and an active flush.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc",     {32'd0, pc1}, 64'd0);
    chk("async_flush3", {63'd0, fl3}, 64'd0);
    chk("async_redir",  {63'd0, rd1}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("post_reset_pc", {32'd0, pc1}, 64'd4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit s, b, j;
      logic [31:0] btgt, jtgt;
      s = ($urandom_range(0, 9) < 4);
      b = ($urandom_range(0, 9) < 2);
      j = ($urandom_range(0, 9) < 2);
      btgt = $urandom();
      jtgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom();
      cycle(s, b, btgt, j, jtgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
